// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost
// thresholds, synchronous flush and optional first-word-fall-through reads.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, almost_full_q, almost_empty_q;
  logic          overflow_q, underflow_q;
  logic          wr_accept, rd_accept;

  // Acceptance looks only at registered flags, so a write while full is
  // dropped even when a read frees a slot on the same edge.
  assign wr_accept = wr_en & ~full_q  & ~flush;
  assign rd_accept = rd_en & ~empty_q & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= (AF_C == '0);
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= (count_d == DEPTH_C);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AF_C);
      almost_empty_q <= (count_d <= AE_C);
      overflow_q     <= ~flush & wr_en & full_q;
      underflow_q    <= ~flush & rd_en & empty_q;
    end
  end

  // Storage is deliberately left out of reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = empty_q ? '0 : mem[rd_ptr_q];
    end else begin : g_reg_read
      logic [DATA_W-1:0] rdata_q;
      always_ff @(posedge clk or negedge res) begin
        if (!res)          rdata_q <= '0;
        else if (rd_accept) rdata_q <= mem[rd_ptr_q];
      end
      assign rdata = rdata_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign count        = count_q;

endmodule
